// File: rtl/add_sched_if.sv
// Bundle of requester, shared-adder and response signals for add_sched.
interface add_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [31:0]         add_data1;
  logic [31:0]         add_data2;
  logic [31:0]         add_result;
  logic                add_v;
  logic                add_c;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_result;
  logic                rsp_v;
  logic                rsp_c;

  modport slave (
    input  req_valid, req_a, req_b,
    input  add_result, add_v, add_c,
    input  rsp_ready,
    output req_ready,
    output add_data1, add_data2,
    output rsp_valid, rsp_id,
    output rsp_result, rsp_v, rsp_c
  );

  modport master (
    output req_valid, req_a, req_b,
    output add_result, add_v, add_c,
    output rsp_ready,
    input  req_ready,
    input  add_data1, add_data2,
    input  rsp_valid, rsp_id,
    input  rsp_result, rsp_v, rsp_c
  );
endinterface

// File: rtl/add_sched.sv
// Round-robin scheduler sharing one adder among N_REQ requesters.
// Define ADD_SCHED_FIXED_PRIO_EN for fixed lowest-index priority.
module add_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic      clk,
  input  logic      reset,
  add_sched_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  state_t state, state_nx;

  logic [31:0]     op_a, op_b;
  logic [ID_W-1:0] gnt_q;
  logic [ID_W-1:0] gnt;
  logic            gnt_any;
  logic [31:0]     sel_a, sel_b;

`ifndef ADD_SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0] rr_ptr;
`endif

  // first valid requester at or above the search start, wrapping
  always_comb begin
    int j;
    logic [ID_W-1:0] idx;
    logic [ID_W+4:0] base;
    j       = 0;
    idx     = '0;
    base    = '0;
    gnt     = '0;
    gnt_any = 1'b0;
    sel_a   = '0;
    sel_b   = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef ADD_SCHED_FIXED_PRIO_EN
      j = k;
`else
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
`endif
      idx  = ID_W'(j);
      base = {idx, 5'b0};
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt     = idx;
        sel_a   = bus.req_a[base +: 32];
        sel_b   = bus.req_b[base +: 32];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && gnt_any && !reset)
      bus.req_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nx = ISSUE;
      ISSUE:   state_nx = HOLD;
      HOLD:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a           <= '0;
      op_b           <= '0;
      gnt_q          <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= '0;
      bus.rsp_result <= '0;
      bus.rsp_v      <= 1'b0;
      bus.rsp_c      <= 1'b0;
    end else begin
      if (state == IDLE && gnt_any) begin
        op_a  <= sel_a;
        op_b  <= sel_b;
        gnt_q <= gnt;
      end
      if (state == ISSUE) begin
        bus.rsp_valid  <= 1'b1;
        bus.rsp_id     <= gnt_q;
        bus.rsp_result <= bus.add_result;
        bus.rsp_v      <= bus.add_v;
        bus.rsp_c      <= bus.add_c;
      end
      if (state == HOLD && bus.rsp_ready)
        bus.rsp_valid <= 1'b0;
    end
  end

`ifndef ADD_SCHED_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (state == HOLD && bus.rsp_ready)
      rr_ptr <= (gnt_q == ID_W'(N_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
  end
`endif

  assign bus.add_data1 = op_a;
  assign bus.add_data2 = op_b;
endmodule
